// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port, optional
// write-through bypass, optional hardwired x0 and a pending-write scoreboard.
module regfile_scoreboard #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned AW       = $clog2(NREGS),
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            flush,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            hazard,
  output logic [AW:0]     pending_cnt
);

  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  // Address names a real, writable register (in range and not hardwired zero).
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < NREGS_W) && !(ZERO_REG && (a == '0));
  endfunction

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;
  logic [AW:0]      cnt_nxt;
  logic             wr_ok;
  logic             iss_ok;

  assign wr_ok  = we && addr_ok(wr_addr);
  assign iss_ok = issue_valid && addr_ok(issue_rd);

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    if (addr_ok(rs1_addr)) begin
      if (BYPASS && wr_ok && (wr_addr == rs1_addr)) begin
        rs1_data = wr_data;
      end else begin
        rs1_data = regs[rs1_addr];
        rs1_busy = pending[rs1_addr];
      end
    end
    if (addr_ok(rs2_addr)) begin
      if (BYPASS && wr_ok && (wr_addr == rs2_addr)) begin
        rs2_data = wr_data;
      end else begin
        rs2_data = regs[rs2_addr];
        rs2_busy = pending[rs2_addr];
      end
    end
  end

  assign hazard = rs1_busy | rs2_busy;

  // Issue beats a same-register write clear; the count tracks only real bit flips.
  always_comb begin
    pending_nxt = pending;
    cnt_nxt     = pending_cnt;
    if (flush) begin
      pending_nxt = '0;
      cnt_nxt     = '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        if (iss_ok && (issue_rd == AW'(r))) begin
          pending_nxt[r] = 1'b1;
        end else if (wr_ok && (wr_addr == AW'(r))) begin
          pending_nxt[r] = 1'b0;
        end
      end
      if (iss_ok && !pending[issue_rd]) begin
        cnt_nxt = cnt_nxt + (AW+1)'(1);
      end
      if (wr_ok && pending[wr_addr] && !(iss_ok && (issue_rd == wr_addr))) begin
        cnt_nxt = cnt_nxt - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending     <= '0;
      pending_cnt <= '0;
    end else begin
      pending     <= pending_nxt;
      pending_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: vector table for the default build plus a
// second instance without bypass and without hardwired x0.
module tb_regfile_scoreboard;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [4:0]  rs1_addr = '0, rs2_addr = '0, wr_addr = '0, issue_rd = '0;
  logic [31:0] wr_data = '0;
  logic        we = 1'b0, issue_valid = 1'b0, flush = 1'b0;

  logic [31:0] rs1_data, rs2_data, rs1_data_b, rs2_data_b;
  logic        rs1_busy, rs2_busy, hazard, rs1_busy_b, rs2_busy_b, hazard_b;
  logic [5:0]  pending_cnt, pending_cnt_b;

  always #5 CLK = ~CLK;

  regfile_scoreboard dut (
    .CLK(CLK), .RST_N(RST_N), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .we(we), .wr_addr(wr_addr),
    .wr_data(wr_data), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .flush(flush), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .hazard(hazard), .pending_cnt(pending_cnt)
  );

  regfile_scoreboard #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data_b), .rs2_data(rs2_data_b), .we(we), .wr_addr(wr_addr),
    .wr_data(wr_data), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .flush(flush), .rs1_busy(rs1_busy_b), .rs2_busy(rs2_busy_b),
    .hazard(hazard_b), .pending_cnt(pending_cnt_b)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  ird;
    logic        fl;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
    logic [5:0]  cnt;
  } vec_t;

  vec_t       vecs[$];
  logic [5:0] exp_q[$];
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one vector, check the combinational outputs, queue the count expected after the edge.
  task automatic apply(input vec_t v, input string tag);
    we = v.we; wr_addr = v.wa; wr_data = v.wd;
    issue_valid = v.iv; issue_rd = v.ird; flush = v.fl;
    rs1_addr = v.a1; rs2_addr = v.a2;
    #1;
    chk({tag, " rs1_data"}, rs1_data, v.d1);
    chk({tag, " rs2_data"}, rs2_data, v.d2);
    chk({tag, " rs1_busy"}, 32'(rs1_busy), 32'(v.b1));
    chk({tag, " rs2_busy"}, 32'(rs2_busy), 32'(v.b2));
    chk({tag, " hazard"}, 32'(hazard), 32'(v.b1 | v.b2));
    exp_q.push_back(v.cnt);
  endtask

  task automatic tick(input string tag);
    logic [5:0] e;
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s scoreboard_empty actual=0 required=1", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " pending_cnt"}, 32'(pending_cnt), 32'(e));
    end
    @(negedge CLK);
  endtask

  function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                              input logic iv, input logic [4:0] ird, input logic fl,
                              input logic [4:0] a1, input logic [4:0] a2,
                              input logic [31:0] d1, input logic [31:0] d2,
                              input logic b1, input logic b2, input logic [5:0] cnt);
    vec_t v;
    v = '{we:w, wa:wa, wd:wd, iv:iv, ird:ird, fl:fl, a1:a1, a2:a2,
          d1:d1, d2:d2, b1:b1, b2:b2, cnt:cnt};
    return v;
  endfunction

  initial begin
    //            we wa  wd            iv ird fl a1  a2  d1            d2            b1 b2 cnt
    vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0,  0, 5,  0,  32'hDEADBEEF, 32'h0,        0, 0, 0)); // 0
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  0, 5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0));
    vecs.push_back(mk(1, 0, 32'h12345678, 1, 0,  0, 0,  0,  32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  0, 0,  0,  32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 7,  0, 5,  7,  32'hDEADBEEF, 32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  0, 5,  7,  32'hDEADBEEF, 32'h0,        0, 1, 1)); // 5
    vecs.push_back(mk(1, 7, 32'hA5,       0, 0,  0, 7,  7,  32'hA5,         32'hA5,       0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  0, 7,  0,  32'hA5,         32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 9,  0, 9,  0,  32'h0,          32'h0,        0, 0, 1));
    vecs.push_back(mk(1, 9, 32'h99,       1, 9,  0, 9,  0,  32'h99,         32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  0, 9,  0,  32'h99,         32'h0,        1, 0, 1)); // 10
    vecs.push_back(mk(0, 0, 32'h0,        1, 4,  0, 9,  0,  32'h99,         32'h0,        1, 0, 2));
    vecs.push_back(mk(1, 4, 32'h44,       1, 3,  0, 4,  3,  32'h44,         32'h0,        0, 0, 2));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  0, 3,  4,  32'h0,          32'h44,       1, 0, 2));
    vecs.push_back(mk(1, 3, 32'h33,       0, 0,  0, 3,  9,  32'h33,         32'h99,       0, 1, 1));
    vecs.push_back(mk(1, 9, 32'h1234,     0, 0,  0, 9,  0,  32'h1234,       32'h0,        0, 0, 0)); // 15
    vecs.push_back(mk(1, 10, 32'hA,       0, 0,  0, 10, 9,  32'hA,          32'h1234,     0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1,  0, 1,  0,  32'h0,          32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        1, 2,  0, 1,  0,  32'h0,          32'h0,        1, 0, 2));
    vecs.push_back(mk(0, 0, 32'h0,        1, 3,  0, 2,  1,  32'h0,          32'h0,        1, 1, 3));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1,  0, 3,  0,  32'h33,         32'h0,        1, 0, 3)); // 20
    vecs.push_back(mk(0, 0, 32'h0,        1, 4,  1, 1,  3,  32'h0,          32'h33,       1, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  0, 4,  1,  32'h44,         32'h0,        0, 0, 0));
    vecs.push_back(mk(1, 5, 32'h55,       0, 0,  1, 5,  4,  32'h55,         32'h44,       0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  0, 5,  10, 32'h55,         32'hA,        0, 0, 0));

    // Reset state: every address reads zero on both ports, nothing pending.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      #1;
      chk($sformatf("reset rs1_data[%0d]", i), rs1_data, 32'h0);
      chk($sformatf("reset rs2_data[%0d]", 31 - i), rs2_data, 32'h0);
      chk($sformatf("reset hazard[%0d]", i), 32'(hazard), 32'h0);
    end
    chk("reset pending_cnt", 32'(pending_cnt), 32'h0);
    @(negedge CLK);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
      tick($sformatf("vec%0d", i));
    end

    // Asynchronous reset with three registers pending.
    apply(mk(0, 0, 0, 1, 11, 0, 0, 0, 0, 0, 0, 0, 1), "rst_a"); tick("rst_a");
    apply(mk(0, 0, 0, 1, 12, 0, 0, 0, 0, 0, 0, 0, 2), "rst_b"); tick("rst_b");
    apply(mk(0, 0, 0, 1, 13, 0, 11, 5, 0, 32'h55, 1, 0, 3), "rst_c"); tick("rst_c");
    issue_valid = 1'b0; rs1_addr = 5'd11; rs2_addr = 5'd5;
    #1;
    chk("pre_rst rs1_busy", 32'(rs1_busy), 32'h1);
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_rst pending_cnt", 32'(pending_cnt), 32'h0);
    chk("async_rst rs1_busy", 32'(rs1_busy), 32'h0);
    chk("async_rst rs2_data", rs2_data, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Bypass/zero-register contrast against the BYPASS=0, ZERO_REG=0 instance.
    apply(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0, 0), "nb_w5");
    chk("nb_w5 b rs1_data", rs1_data_b, 32'h0);
    tick("nb_w5");
    apply(mk(0, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0, 0), "nb_r5");
    chk("nb_r5 b rs1_data", rs1_data_b, 32'hDEADBEEF);
    tick("nb_r5");
    apply(mk(1, 0, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "nb_w0");
    chk("nb_w0 b rs1_data", rs1_data_b, 32'h0);
    tick("nb_w0");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "nb_r0");
    chk("nb_r0 b rs1_data", rs1_data_b, 32'h12345678);
    tick("nb_r0");
    apply(mk(0, 0, 0, 1, 7, 0, 0, 7, 0, 0, 0, 0, 1), "nb_i7");
    tick("nb_i7");
    chk("nb_i7 b pending_cnt", 32'(pending_cnt_b), 32'h1);
    apply(mk(1, 7, 32'hA5, 0, 0, 0, 0, 7, 0, 32'hA5, 0, 0, 0), "nb_w7");
    chk("nb_w7 b rs2_busy", 32'(rs2_busy_b), 32'h1);
    chk("nb_w7 b hazard", 32'(hazard_b), 32'h1);
    chk("nb_w7 b rs2_data", rs2_data_b, 32'h0);
    tick("nb_w7");
    chk("nb_w7 b pending_cnt", 32'(pending_cnt_b), 32'h0);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 7, 0, 32'hA5, 0, 0, 0), "nb_r7");
    chk("nb_r7 b rs2_busy", 32'(rs2_busy_b), 32'h0);
    chk("nb_r7 b rs2_data", rs2_data_b, 32'hA5);
    tick("nb_r7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
